// File: rtl/sram_tdm_ctrl_if.sv
// sram_tdm_ctrl_if: bundles the requester bus and the SRAM pin bus of the
// time-division SRAM controller.
//
// Requester side (per channel k, flattened vectors):
//   ch_req[k]               request level, held until ch_ack[k]
//   ch_wr[k]                1 = write, 0 = read
//   ch_addr[k*AW +: AW]     word address
//   ch_be[k*2 +: 2]         byte enables (bit0 low byte, bit1 high byte)
//   ch_wdata[k*16 +: 16]    write data
//   ch_ack[k]               one-cycle completion pulse
//   ch_rdata[k*16 +: 16]    last read data for channel k
// SRAM side: sram_addr, sram_ce_n/oe_n/we_n/lb_n/ub_n, sram_dq_o,
//   sram_dq_oe (pad tristate enable), sram_dq_i (pad input).
// Status: slot (current slot), dbg_phase, dbg_gnt_vld, dbg_gnt_ch.
//
// Handshake: a requester raises ch_req[k] with its command fields stable and
// keeps it high until it sees ch_ack[k]. The command is taken when the grant
// is registered; ch_ack[k] pulses for exactly one cycle when the access is
// done, with ch_rdata already updated for reads. In the ack cycle the
// requester drops ch_req[k] or presents its next command; a request still
// high at the next eligible slot is a new access.
interface sram_tdm_ctrl_if #(
    parameter int NCH = 4,
    parameter int AW  = 18
);
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_wr;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*2-1:0]  ch_be;
    logic [NCH*16-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ack;
    logic [NCH*16-1:0] ch_rdata;
    logic [2:0]        slot;
    logic [AW-1:0]     sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_lb_n;
    logic              sram_ub_n;
    logic [15:0]       sram_dq_o;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_i;
    logic [2:0]        dbg_phase;
    logic              dbg_gnt_vld;
    logic [2:0]        dbg_gnt_ch;

    modport master (
        output ch_req, ch_wr, ch_addr, ch_be, ch_wdata, sram_dq_i,
        input  ch_ack, ch_rdata, slot, sram_addr, sram_ce_n, sram_oe_n,
               sram_we_n, sram_lb_n, sram_ub_n, sram_dq_o, sram_dq_oe,
               dbg_phase, dbg_gnt_vld, dbg_gnt_ch
    );

    modport slave (
        input  ch_req, ch_wr, ch_addr, ch_be, ch_wdata, sram_dq_i,
        output ch_ack, ch_rdata, slot, sram_addr, sram_ce_n, sram_oe_n,
               sram_we_n, sram_lb_n, sram_ub_n, sram_dq_o, sram_dq_oe,
               dbg_phase, dbg_gnt_vld, dbg_gnt_ch
    );
endinterface

// File: rtl/sram_tdm_ctrl.sv
// sram_tdm_ctrl: time-division controller for one asynchronous 16-bit SRAM.
// Time is cut into slots of SLOT_CYC mclk cycles; slot n belongs to channel n.
// With STEAL=1 a slot whose owner is idle goes to the lowest-numbered other
// requesting channel. Every SRAM pin is driven straight from a flop.
//
// Ports:
//   mclk   controller clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    sram_tdm_ctrl_if slave modport (requesters + SRAM pins + status)
module sram_tdm_ctrl #(
    parameter int NCH      = 4,
    parameter int AW       = 18,
    parameter int SLOT_CYC = 3,
    parameter int STEAL    = 1
) (
    input  logic          mclk,
    input  logic          rst_n,
    sram_tdm_ctrl_if.slave bus
);
    localparam logic [2:0] LAST_PH   = 3'(SLOT_CYC - 1);
    localparam logic [2:0] WE_LAST   = 3'(SLOT_CYC - 2);
    localparam logic [2:0] LAST_SLOT = 3'(NCH - 1);

    logic [2:0]        phase_q, phase_d;
    logic [2:0]        slot_q, slot_d;
    logic              gnt_vld_q, gnt_vld_d;
    logic [2:0]        gnt_ch_q, gnt_ch_d;
    logic              gnt_wr_q, gnt_wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              lb_n_q, lb_n_d;
    logic              ub_n_q, ub_n_d;
    logic [15:0]       dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d;
    logic [NCH-1:0]    ack_q, ack_d;
    logic [NCH*16-1:0] rdata_q, rdata_d;

    logic              last_ph;
    logic [2:0]        owner;
    logic [NCH-1:0]    elig;
    logic              owner_req;
    logic              nxt_vld;
    logic [2:0]        nxt_ch;
    logic [AW-1:0]     sel_addr;
    logic [1:0]        sel_be;
    logic [15:0]       sel_wdata;
    logic              sel_wr;

    // Grant decision for the slot that starts at the next edge.
    always_comb begin
        last_ph   = (phase_q == LAST_PH);
        owner     = (slot_q == LAST_SLOT) ? 3'd0 : 3'(slot_q + 3'd1);
        elig      = bus.ch_req;
        owner_req = 1'b0;
        nxt_vld   = 1'b0;
        nxt_ch    = 3'd0;
        sel_addr  = '0;
        sel_be    = 2'b00;
        sel_wdata = 16'h0000;
        sel_wr    = 1'b0;
        // The channel served in the current slot still holds its request
        // until its ack next cycle, so it is never eligible again here,
        // not even as owner; otherwise the same command would run twice.
        for (int k = 0; k < NCH; k++) begin
            if (gnt_vld_q && (3'(k) == gnt_ch_q)) elig[k] = 1'b0;
        end
        for (int k = 0; k < NCH; k++) begin
            if (3'(k) == owner) owner_req = elig[k];
        end
        if (owner_req) begin
            nxt_vld = 1'b1;
            nxt_ch  = owner;
        end else if (STEAL != 0) begin
            // Descending scan so the lowest requesting index wins.
            for (int k = NCH - 1; k >= 0; k--) begin
                if (elig[k]) begin
                    nxt_vld = 1'b1;
                    nxt_ch  = 3'(k);
                end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (3'(k) == nxt_ch) begin
                sel_addr  = bus.ch_addr[k*AW +: AW];
                sel_be    = bus.ch_be[k*2 +: 2];
                sel_wdata = bus.ch_wdata[k*16 +: 16];
                sel_wr    = bus.ch_wr[k];
            end
        end
    end

    // Next-state for counters, grant register and pin flops.
    always_comb begin
        phase_d   = last_ph ? 3'd0 : 3'(phase_q + 3'd1);
        slot_d    = last_ph ? owner : slot_q;
        gnt_vld_d = gnt_vld_q;
        gnt_ch_d  = gnt_ch_q;
        gnt_wr_d  = gnt_wr_q;
        addr_d    = addr_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        lb_n_d    = lb_n_q;
        ub_n_d    = ub_n_q;
        dq_o_d    = dq_o_q;
        dq_oe_d   = dq_oe_q;
        ack_d     = '0;
        rdata_d   = rdata_q;

        if (last_ph) begin
            // Close the current access: ack plus read capture on this edge.
            for (int k = 0; k < NCH; k++) begin
                if (gnt_vld_q && (3'(k) == gnt_ch_q)) begin
                    ack_d[k] = 1'b1;
                    if (!gnt_wr_q) rdata_d[k*16 +: 16] = bus.sram_dq_i;
                end
            end
            gnt_vld_d = nxt_vld;
            gnt_ch_d  = nxt_ch;
            gnt_wr_d  = nxt_vld && sel_wr;
            if (nxt_vld) begin
                addr_d  = sel_addr;
                ce_n_d  = 1'b0;
                oe_n_d  = sel_wr;
                lb_n_d  = !sel_be[0];
                ub_n_d  = !sel_be[1];
                dq_oe_d = sel_wr;
                if (sel_wr) dq_o_d = sel_wdata;
            end else begin
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                lb_n_d  = 1'b1;
                ub_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        end

        // Strobe only in the inner phases: one cycle of setup and hold
        // around we_n for address, data and byte enables.
        we_n_d = !(gnt_vld_d && gnt_wr_d &&
                   (phase_d >= 3'd1) && (phase_d <= WE_LAST));
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= 3'd0;
            slot_q    <= 3'd0;
            gnt_vld_q <= 1'b0;
            gnt_ch_q  <= 3'd0;
            gnt_wr_q  <= 1'b0;
            addr_q    <= '0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            dq_o_q    <= 16'h0000;
            dq_oe_q   <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            slot_q    <= slot_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_ch_q  <= gnt_ch_d;
            gnt_wr_q  <= gnt_wr_d;
            addr_q    <= addr_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            lb_n_q    <= lb_n_d;
            ub_n_q    <= ub_n_d;
            dq_o_q    <= dq_o_d;
            dq_oe_q   <= dq_oe_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.ch_ack      = ack_q;
    assign bus.ch_rdata    = rdata_q;
    assign bus.slot        = slot_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_lb_n   = lb_n_q;
    assign bus.sram_ub_n   = ub_n_q;
    assign bus.sram_dq_o   = dq_o_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.dbg_phase   = phase_q;
    assign bus.dbg_gnt_vld = gnt_vld_q;
    assign bus.dbg_gnt_ch  = gnt_ch_q;
endmodule

// File: tb/tb_sram_tdm_ctrl.sv
// Bench for sram_tdm_ctrl. Three instances share mclk:
//   A: NCH=4 SLOT_CYC=3 STEAL=1 (table vectors, contention, reset mid-write)
//   B: NCH=4 SLOT_CYC=3 STEAL=0 (owner-only wait)
//   C: NCH=2 SLOT_CYC=5 STEAL=1 (long slot strobe window)
module tb_sram_tdm_ctrl;
    logic mclk = 1'b0;
    logic rst_a_n = 1'b1;
    logic rst_b_n = 1'b1;
    logic rst_c_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_a = 0;
    int   cyc_b = 0;
    int   cyc_c = 0;
    logic [18:0] exp_q[$];   // {channel, expected ch_rdata} per ack on A

    always #5 mclk = ~mclk;

    sram_tdm_ctrl_if #(.NCH(4), .AW(18)) a_if ();
    sram_tdm_ctrl_if #(.NCH(4), .AW(18)) b_if ();
    sram_tdm_ctrl_if #(.NCH(2), .AW(18)) c_if ();

    sram_tdm_ctrl #(.NCH(4), .AW(18), .SLOT_CYC(3), .STEAL(1)) dut_a (
        .mclk(mclk), .rst_n(rst_a_n), .bus(a_if));
    sram_tdm_ctrl #(.NCH(4), .AW(18), .SLOT_CYC(3), .STEAL(0)) dut_b (
        .mclk(mclk), .rst_n(rst_b_n), .bus(b_if));
    sram_tdm_ctrl #(.NCH(2), .AW(18), .SLOT_CYC(5), .STEAL(1)) dut_c (
        .mclk(mclk), .rst_n(rst_c_n), .bus(c_if));

    // Reference time base: edges since reset release.
    always @(posedge mclk or negedge rst_a_n)
        if (!rst_a_n) cyc_a <= 0; else cyc_a <= cyc_a + 1;
    always @(posedge mclk or negedge rst_b_n)
        if (!rst_b_n) cyc_b <= 0; else cyc_b <= cyc_b + 1;
    always @(posedge mclk or negedge rst_c_n)
        if (!rst_c_n) cyc_c <= 0; else cyc_c <= cyc_c + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slot number model for every instance.
    always @(negedge mclk) begin
        if (rst_a_n) chk("a_slot_seq", 32'(a_if.slot), 32'((cyc_a / 3) % 4));
        if (rst_b_n) chk("b_slot_seq", 32'(b_if.slot), 32'((cyc_b / 3) % 4));
        if (rst_c_n) chk("c_slot_seq", 32'(c_if.slot), 32'((cyc_c / 5) % 2));
    end

    // Scoreboard on A: every ack pops the oldest expectation.
    always @(negedge mclk) begin
        if (rst_a_n && (a_if.ch_ack != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                chk("a_ack_unexpected", 32'(a_if.ch_ack), 32'h0);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                chk("sb_ack_onehot", 32'($onehot(a_if.ch_ack)), 32'h1);
                chk("sb_ack_ch", 32'(a_if.ch_ack), 32'(1) << e[18:16]);
                chk("sb_rdata", 32'(a_if.ch_rdata[e[18:16]*16 +: 16]), 32'(e[15:0]));
            end
        end
    end

    // Wait for the negedge inside phase ph of slot sl of instance which.
    task automatic align(input int which, input int ph, input int sl);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge mclk);
            case (which)
                0: ok = (cyc_a % 3 == ph) && ((cyc_a / 3) % 4 == sl);
                1: ok = (cyc_b % 3 == ph) && ((cyc_b / 3) % 4 == sl);
                default: ok = (cyc_c % 5 == ph) && ((cyc_c / 5) % 2 == sl);
            endcase
        end
        if (!ok) chk("align_timeout", 32'h0, 32'h1);
    endtask

    typedef struct {
        logic [2:0]  pre;
        logic [2:0]  ch;
        logic        wr;
        logic [17:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] dq;
        logic [2:0]  exp_slot;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        align(0, 2, int'(v.pre));
        a_if.ch_req[v.ch]           = 1'b1;
        a_if.ch_wr[v.ch]            = v.wr;
        a_if.ch_addr[v.ch*18 +: 18] = v.addr;
        a_if.ch_be[v.ch*2 +: 2]     = v.be;
        a_if.ch_wdata[v.ch*16 +: 16] = v.wdata;
        a_if.sram_dq_i              = v.dq;
        exp_q.push_back({v.ch, v.exp_rdata});
        for (int p = 0; p < 3; p++) begin
            @(negedge mclk);
            chk("v_slot", 32'(a_if.slot), 32'(v.exp_slot));
            chk("v_ce_n", 32'(a_if.sram_ce_n), 32'h0);
            chk("v_addr", 32'(a_if.sram_addr), 32'(v.addr));
            chk("v_lb_n", 32'(a_if.sram_lb_n), 32'(!v.be[0]));
            chk("v_ub_n", 32'(a_if.sram_ub_n), 32'(!v.be[1]));
            chk("v_oe_n", 32'(a_if.sram_oe_n), 32'(v.wr));
            chk("v_dq_oe", 32'(a_if.sram_dq_oe), 32'(v.wr));
            chk("v_we_n", 32'(a_if.sram_we_n), 32'(!(v.wr && p == 1)));
            chk("v_ack_idle", 32'(a_if.ch_ack), 32'h0);
            if (v.wr) chk("v_dq_o", 32'(a_if.sram_dq_o), 32'(v.wdata));
            if (p == 0) begin
                // Command fields change mid-slot; the running access must not.
                a_if.ch_addr[v.ch*18 +: 18]  = 18'($urandom);
                a_if.ch_wdata[v.ch*16 +: 16] = 16'($urandom);
                a_if.ch_be[v.ch*2 +: 2]      = 2'($urandom_range(0, 3));
                a_if.ch_wr[v.ch]             = ~v.wr;
            end
        end
        @(negedge mclk);
        chk("v_ack", 32'(a_if.ch_ack), 32'(1) << v.ch);
        chk("v_rdata", 32'(a_if.ch_rdata[v.ch*16 +: 16]), 32'(v.exp_rdata));
        chk("v_idle_ce_n", 32'(a_if.sram_ce_n), 32'h1);
        a_if.ch_req[v.ch] = 1'b0;
        a_if.ch_wr[v.ch]  = 1'b0;
        // The served channel must not be picked again for this slot.
        repeat (2) begin
            @(negedge mclk);
            chk("v_no_regrant", 32'(a_if.sram_ce_n), 32'h1);
        end
    endtask

    task automatic run_c(input int pre, input int ch, input logic wr, input logic [17:0] addr,
                         input logic [15:0] wdata, input logic [15:0] dq, input logic [15:0] exp_rd);
        align(2, 4, pre);
        c_if.ch_req[ch]           = 1'b1;
        c_if.ch_wr[ch]            = wr;
        c_if.ch_addr[ch*18 +: 18] = addr;
        c_if.ch_be[ch*2 +: 2]     = 2'b11;
        c_if.ch_wdata[ch*16 +: 16] = wdata;
        c_if.sram_dq_i            = dq;
        for (int p = 0; p < 5; p++) begin
            @(negedge mclk);
            chk("c_ce_n", 32'(c_if.sram_ce_n), 32'h0);
            chk("c_addr", 32'(c_if.sram_addr), 32'(addr));
            chk("c_we_n", 32'(c_if.sram_we_n), 32'(!(wr && p >= 1 && p <= 3)));
            chk("c_oe_n", 32'(c_if.sram_oe_n), 32'(wr));
            chk("c_dq_oe", 32'(c_if.sram_dq_oe), 32'(wr));
            chk("c_ack_idle", 32'(c_if.ch_ack), 32'h0);
        end
        @(negedge mclk);
        chk("c_ack", 32'(c_if.ch_ack), 32'(1) << ch);
        chk("c_rdata", 32'(c_if.ch_rdata[ch*16 +: 16]), 32'(exp_rd));
        c_if.ch_req[ch] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 3'd1, 1'b0, 18'h01234, 2'b11, 16'h0000, 16'hBEEF, 3'd1, 16'hBEEF};
        vecs[1] = '{3'd1, 3'd2, 1'b1, 18'h3FFFF, 2'b10, 16'hA55A, 16'h0000, 3'd2, 16'h0000};
        vecs[2] = '{3'd3, 3'd3, 1'b0, 18'h2AAAA, 2'b11, 16'h0000, 16'h1357, 3'd0, 16'h1357};
        vecs[3] = '{3'd1, 3'd0, 1'b0, 18'h15555, 2'b01, 16'h0000, 16'hC3C3, 3'd2, 16'hC3C3};
        vecs[4] = '{3'd2, 3'd1, 1'b1, 18'h00000, 2'b00, 16'hFFFF, 16'h0000, 3'd3, 16'hBEEF};
        vecs[5] = '{3'd3, 3'd0, 1'b1, 18'h20001, 2'b01, 16'h0F0F, 16'h0000, 3'd0, 16'hC3C3};
        vecs[6] = '{3'd2, 3'd3, 1'b0, 18'h3FFFE, 2'b11, 16'h0000, 16'h8001, 3'd3, 16'h8001};
        vecs[7] = '{3'd1, 3'd2, 1'b0, 18'h00FFF, 2'b10, 16'h0000, 16'h7E7E, 3'd2, 16'h7E7E};
        vecs[8] = '{3'd1, 3'd1, 1'b0, 18'h11111, 2'b11, 16'h0000, 16'h4242, 3'd2, 16'h4242};
        vecs[9] = '{3'd3, 3'd2, 1'b1, 18'h2468A, 2'b11, 16'h9999, 16'h0000, 3'd0, 16'h7E7E};

        a_if.ch_req = '0; a_if.ch_wr = '0; a_if.ch_addr = '0; a_if.ch_be = '0;
        a_if.ch_wdata = '0; a_if.sram_dq_i = '0;
        b_if.ch_req = '0; b_if.ch_wr = '0; b_if.ch_addr = '0; b_if.ch_be = '0;
        b_if.ch_wdata = '0; b_if.sram_dq_i = '0;
        c_if.ch_req = '0; c_if.ch_wr = '0; c_if.ch_addr = '0; c_if.ch_be = '0;
        c_if.ch_wdata = '0; c_if.sram_dq_i = '0;

        // Reset values.
        #1 rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        #2;
        chk("rst_ack", 32'(a_if.ch_ack), 32'h0);
        chk("rst_rdata", 32'(a_if.ch_rdata[31:0]), 32'h0);
        chk("rst_slot", 32'(a_if.slot), 32'h0);
        chk("rst_ctl", {27'h0, a_if.sram_ce_n, a_if.sram_oe_n, a_if.sram_we_n,
                        a_if.sram_lb_n, a_if.sram_ub_n}, 32'h1F);
        chk("rst_addr", 32'(a_if.sram_addr), 32'h0);
        chk("rst_dq", {15'h0, a_if.sram_dq_oe, a_if.sram_dq_o}, 32'h0);
        chk("rst_b_ce_n", 32'(b_if.sram_ce_n), 32'h1);
        chk("rst_c_ce_n", 32'(c_if.sram_ce_n), 32'h1);
        repeat (2) @(negedge mclk);
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Full contention: strict rotation 1,2,3,0,... one ack per slot.
        align(0, 2, 0);
        a_if.ch_wr = '0;
        a_if.sram_dq_i = 16'h6C6C;
        for (int i = 0; i < 8; i++) exp_q.push_back({3'((1 + i) % 4), 16'h6C6C});
        a_if.ch_req = 4'hF;
        repeat (22) @(negedge mclk);
        a_if.ch_req = 4'h0;
        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 40) begin
                @(negedge mclk);
                t++;
            end
            chk("cont_drained", 32'(exp_q.size()), 32'h0);
        end
        repeat (6) @(negedge mclk);

        // Reset during the strobe of a write: pins drop at once, no ack.
        align(0, 2, 0);
        a_if.ch_req[1] = 1'b1; a_if.ch_wr[1] = 1'b1;
        a_if.ch_addr[18 +: 18] = 18'h0ABCD; a_if.ch_be[3:2] = 2'b11;
        a_if.ch_wdata[31:16] = 16'h1234;
        @(negedge mclk);
        chk("rw_ce_n", 32'(a_if.sram_ce_n), 32'h0);
        @(negedge mclk);
        chk("rw_we_n", 32'(a_if.sram_we_n), 32'h0);
        rst_a_n = 1'b0;
        #1;
        chk("rw_we_n_rst", 32'(a_if.sram_we_n), 32'h1);
        chk("rw_ce_n_rst", 32'(a_if.sram_ce_n), 32'h1);
        chk("rw_dq_oe_rst", 32'(a_if.sram_dq_oe), 32'h0);
        chk("rw_slot_rst", 32'(a_if.slot), 32'h0);
        chk("rw_rdata_rst", 32'(a_if.ch_rdata[63:32]), 32'h0);
        chk("rw_addr_rst", 32'(a_if.sram_addr), 32'h0);
        a_if.ch_req = '0; a_if.ch_wr = '0;
        @(negedge mclk);
        rst_a_n = 1'b1;
        repeat (8) begin
            @(negedge mclk);
            chk("rw_no_ack", 32'(a_if.ch_ack), 32'h0);
            chk("rw_idle", 32'(a_if.sram_ce_n), 32'h1);
        end

        // STEAL=0: channel 3 idles through slots 0..2 and is served in 3.
        align(1, 2, 3);
        b_if.ch_req[3] = 1'b1;
        b_if.ch_addr[54 +: 18] = 18'h00042;
        b_if.ch_be[7:6] = 2'b11;
        b_if.sram_dq_i = 16'hD00D;
        for (int i = 0; i < 12; i++) begin
            @(negedge mclk);
            chk("b_ce_n", 32'(b_if.sram_ce_n), (i / 3 == 3) ? 32'h0 : 32'h1);
            chk("b_ack_idle", 32'(b_if.ch_ack), 32'h0);
        end
        @(negedge mclk);
        chk("b_ack", 32'(b_if.ch_ack), 32'h8);
        chk("b_rdata", 32'(b_if.ch_rdata[63:48]), 32'hD00D);
        b_if.ch_req = '0;

        // SLOT_CYC=5, NCH=2.
        run_c(1, 0, 1'b1, 18'h00777, 16'h5AA5, 16'h0000, 16'h0000);
        run_c(0, 1, 1'b0, 18'h3C3C3, 16'h0000, 16'hFACE, 16'hFACE);
        chk("c_rdata0_kept", 32'(c_if.ch_rdata[15:0]), 32'h0);

        repeat (4) @(negedge mclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_tdm_ctrl.md
Name: sram_tdm_ctrl

Overview:
- Parametrised time-division SRAM controller for one asynchronous 16-bit SRAM.
- Next generation of the two-phase video/CPU SRAM sequencer: NCH requesters with fixed, rotating slot ownership.
- Adds configurable slot length, a full data path with tristate control, per-byte enables, a req/ack handshake, and optional reuse of idle slots.
- Sits between the video fetcher, Z80 bus, DMA and other masters and the board SRAM pins.

Parameters:
- NCH, 4, number of requesting channels (2..8); slot n is owned by channel n.
- AW, 18, SRAM word address width.
- SLOT_CYC, 3, mclk cycles per slot (3..8).
- STEAL, 1, if 1, an unused slot is granted to the lowest-numbered other requesting channel.

Ports:
- mclk  in  1  controller clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- ch_req  in  NCH  per-channel request level; held until ch_ack.
- ch_wr  in  NCH  per-channel write (1) / read (0).
- ch_addr  in  NCH*AW  word addresses; channel k at [k*AW +: AW].
- ch_be  in  NCH*2  byte enables; bit0 = low byte, bit1 = high byte.
- ch_wdata  in  NCH*16  write data.
- ch_ack  out  NCH  one-cycle completion pulse.
- ch_rdata  out  NCH*16  per-channel read data register.
- slot  out  3  current slot number.
- sram_addr  out  AW  SRAM address.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  SRAM controls.
- sram_dq_o  out  16  write data.
- sram_dq_oe  out  1  tristate enable for the top-level pad.
- sram_dq_i  in  16  read data from the pad.

Behaviour:
- Counters: phase counts 0..SLOT_CYC-1 and wraps; slot increments when phase wraps, modulo NCH.
- Reset: phase=0, slot=0, ch_ack=0, ch_rdata=0, ce_n/oe_n/we_n/lb_n/ub_n=1, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, no active grant.
- Reset mid-operation: all outputs return to the reset values asynchronously. The access is abandoned with no ack, and the requester must re-request.
- Grant decision: made in the last phase of the preceding slot, registered at the slot boundary.
  - Owner request: owner = next slot number; if ch_req[owner], grant owner.
  - Otherwise, if STEAL=1, grant the lowest-indexed k with ch_req[k]=1, excluding the channel granted in the current slot (its ack is still pending).
  - Otherwise no grant: ce_n=1, oe_n=1, we_n=1, dq_oe=0 for the whole slot.
- Granted slot, phase 0..SLOT_CYC-1: sram_addr, ce_n=0, lb_n=!be[0], ub_n=!be[1] held constant for the whole slot.
- Read access: oe_n=0 for the whole slot; dq_oe=0.
- Write access:
  - oe_n=1; dq_oe=1 and sram_dq_o=wdata for the whole slot.
  - we_n=0 only in phases 1..SLOT_CYC-2, so address, data and byte enables are set up one cycle before and held one cycle after the write strobe.
- Read capture: sram_dq_i is registered into ch_rdata[granted] at the posedge ending phase SLOT_CYC-1. ch_rdata for other channels is unchanged. Writes never modify ch_rdata.
- Ack: ch_ack[granted]=1 for exactly one cycle (phase 0 of the next slot), coincident with new ch_rdata. At most one ack bit is high in any cycle.
- Latency: request sampled at the last phase before the slot, ack SLOT_CYC cycles later. Worst-case wait for an owner-only channel is NCH*SLOT_CYC cycles.
- ch_be=00 with a grant: a full slot runs with ce_n=0, lb_n=ub_n=1, and is acked normally.
- Requester must deassert ch_req, or present the next request, in the ack cycle. If ch_req is still high at its next eligible slot, a new access runs.
- Inputs other than ch_req are sampled only together with the grant; changes mid-slot have no effect.
- Back-to-back grants to different channels: the boundary cycle switches address, controls and dq_oe in the same edge. No control is asserted across the boundary because we_n is already high in the last phase.

Test Plan:
- Owner read: NCH=4, SLOT_CYC=3, ch_req[1]=1 read addr 0x1234, sram_dq_i=0xBEEF -> sram_addr=0x1234, ce_n=oe_n=0 for 3 cycles in slot 1, ch_ack[1] pulses once at slot 2 phase 0, ch_rdata[1]=0xBEEF.
- Byte write: ch2 write addr 0x3FFFF, be=10, wdata=0xA55A -> ub_n=0, lb_n=1, dq_oe=1 for 3 cycles, we_n low only in phase 1, sram_dq_o=0xA55A, ch_ack[2] one cycle, ch_rdata[2] unchanged.
- Steal: STEAL=1, only ch3 requesting, slot 0 next -> ch3 served in slot 0; ch3 not re-granted in slot 1, ch_ack[3] at slot 1 phase 0. With STEAL=0, ch3 waits for slot 3.
- Full contention: all four channels hold req continuously -> grants are exactly 0,1,2,3,0..., one ack every 3 cycles, no simultaneous acks.
- Reset mid-write: assert rst_n low during phase 1 of a write -> we_n, ce_n, dq_oe go inactive immediately; no ack; slot=0, phase=0 after release.
- SLOT_CYC=5, NCH=2 -> we_n low exactly in phases 1..3, ack latency 5 cycles, slot sequence alternates 0,1.
